// File: rtl/wb_sram_loader.sv
// Wishbone classic slave that lets the host load the IRAM/DRAM macros and
// release the core from reset through a RUN control bit.
module wb_sram_loader #(
    parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        iram_csb_a_o,
    output logic        iram_csb_b_o,
    output logic        dram_csb_o,
    output logic        sram_web_o,
    output logic [3:0]  sram_wmask_o,
    output logic [7:0]  sram_addr_o,
    output logic [31:0] sram_din_o,
    input  logic [31:0] iram_dout_a_i,
    input  logic [31:0] iram_dout_b_i,
    input  logic [31:0] dram_dout_i,
    output logic        core_rst_n_o
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WR   = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_RDW  = 3'd3;
    localparam logic [2:0] S_ACK  = 3'd4;

    localparam logic [1:0] R_IRAM_A = 2'd0;
    localparam logic [1:0] R_IRAM_B = 2'd1;
    localparam logic [1:0] R_DRAM   = 2'd2;
    localparam logic [1:0] R_CTRL   = 2'd3;

    logic [2:0]  state_q, state_d;
    logic        csb_a_q, csb_a_d;
    logic        csb_b_q, csb_b_d;
    logic        csb_dr_q, csb_dr_d;
    logic        web_q, web_d;
    logic [3:0]  wmask_q, wmask_d;
    logic [7:0]  addr_q, addr_d;
    logic [31:0] din_q, din_d;
    logic        ack_q, ack_d;
    logic [31:0] rdat_q, rdat_d;
    logic        run_q, run_d;
    logic        core_rst_n_q;
    logic [1:0]  region_q, region_d;
    logic        we_q, we_d;
    logic        word0_q, word0_d;
    logic        run_wr_q, run_wr_d;
    logic        run_val_q, run_val_d;

    logic        req_hit;
    logic        req_sram;
    logic        unused_adr_lsb;

    assign req_hit  = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:12] == BASE_ADR[31:12]);
    // Once RUN is set the macros belong to the core, so the bus is only acked.
    assign req_sram = (wbs_adr_i[11:10] != R_CTRL) & ~run_q;
    assign unused_adr_lsb = ^wbs_adr_i[1:0];

    always_comb begin
        state_d   = state_q;
        csb_a_d   = 1'b1;
        csb_b_d   = 1'b1;
        csb_dr_d  = 1'b1;
        web_d     = 1'b1;
        wmask_d   = 4'h0;
        addr_d    = addr_q;
        din_d     = din_q;
        ack_d     = 1'b0;
        rdat_d    = rdat_q;
        run_d     = run_q;
        region_d  = region_q;
        we_d      = we_q;
        word0_d   = word0_q;
        run_wr_d  = run_wr_q;
        run_val_d = run_val_q;

        case (state_q)
            S_IDLE: begin
                if (req_hit) begin
                    region_d  = wbs_adr_i[11:10];
                    we_d      = wbs_we_i;
                    word0_d   = (wbs_adr_i[9:2] == 8'd0);
                    run_wr_d  = wbs_we_i & (wbs_adr_i[11:10] == R_CTRL) &
                                (wbs_adr_i[9:2] == 8'd0) & wbs_sel_i[0];
                    run_val_d = wbs_dat_i[0];
                    if (req_sram) begin
                        addr_d = wbs_adr_i[9:2];
                        case (wbs_adr_i[11:10])
                            R_IRAM_A: csb_a_d  = 1'b0;
                            R_IRAM_B: csb_b_d  = 1'b0;
                            default:  csb_dr_d = 1'b0;
                        endcase
                        if (wbs_we_i) begin
                            web_d   = 1'b0;
                            wmask_d = wbs_sel_i;
                            din_d   = wbs_dat_i;
                            state_d = S_WR;
                        end else begin
                            state_d = S_RD;
                        end
                    end else begin
                        state_d = S_WR;
                    end
                end
            end
            S_WR: begin
                // A RUN write completes even if the master abandons the cycle.
                if (run_wr_q) begin
                    run_d = run_val_q;
                end
                if (wbs_cyc_i) begin
                    state_d = S_ACK;
                    ack_d   = 1'b1;
                    if (!we_q) begin
                        rdat_d = (region_q == R_CTRL && word0_q) ? {31'b0, run_q} : 32'h0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD: begin
                state_d = wbs_cyc_i ? S_RDW : S_IDLE;
            end
            S_RDW: begin
                if (wbs_cyc_i) begin
                    state_d = S_ACK;
                    ack_d   = 1'b1;
                    case (region_q)
                        R_IRAM_A: rdat_d = iram_dout_a_i;
                        R_IRAM_B: rdat_d = iram_dout_b_i;
                        default:  rdat_d = dram_dout_i;
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q      <= S_IDLE;
            csb_a_q      <= 1'b1;
            csb_b_q      <= 1'b1;
            csb_dr_q     <= 1'b1;
            web_q        <= 1'b1;
            wmask_q      <= 4'h0;
            addr_q       <= 8'h0;
            din_q        <= 32'h0;
            ack_q        <= 1'b0;
            rdat_q       <= 32'h0;
            run_q        <= 1'b0;
            core_rst_n_q <= 1'b0;
            region_q     <= 2'd0;
            we_q         <= 1'b0;
            word0_q      <= 1'b0;
            run_wr_q     <= 1'b0;
            run_val_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            csb_a_q      <= csb_a_d;
            csb_b_q      <= csb_b_d;
            csb_dr_q     <= csb_dr_d;
            web_q        <= web_d;
            wmask_q      <= wmask_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
            ack_q        <= ack_d;
            rdat_q       <= rdat_d;
            run_q        <= run_d;
            core_rst_n_q <= run_q;
            region_q     <= region_d;
            we_q         <= we_d;
            word0_q      <= word0_d;
            run_wr_q     <= run_wr_d;
            run_val_q    <= run_val_d;
        end
    end

    assign wbs_ack_o    = ack_q;
    assign wbs_dat_o    = rdat_q;
    assign iram_csb_a_o = csb_a_q;
    assign iram_csb_b_o = csb_b_q;
    assign dram_csb_o   = csb_dr_q;
    assign sram_web_o   = web_q;
    assign sram_wmask_o = wmask_q;
    assign sram_addr_o  = addr_q;
    assign sram_din_o   = din_q;
    assign core_rst_n_o = core_rst_n_q;

endmodule

// File: tb/tb_wb_sram_loader.sv
// Randomized bench for wb_sram_loader: transaction-level reference model with
// per-cycle output comparison, plus macro models that answer the DUT.
module tb_wb_sram_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0, cyc = 1'b0, we_i = 1'b0;
    logic [3:0]  sel_i = 4'h0;
    logic [31:0] adr_i = 32'h0, dat_i = 32'h0;
    logic        ack;
    logic [31:0] dat_o;
    logic        csb_a, csb_b, csb_d, web;
    logic [3:0]  wmask;
    logic [7:0]  addr;
    logic [31:0] din;
    logic [31:0] dout_a = 32'h0, dout_b = 32'h0, dout_d = 32'h0;
    logic        core_rst_n;

    always #5 clk = ~clk;

    wb_sram_loader dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we_i), .wbs_sel_i(sel_i),
        .wbs_adr_i(adr_i), .wbs_dat_i(dat_i), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .iram_csb_a_o(csb_a), .iram_csb_b_o(csb_b), .dram_csb_o(csb_d),
        .sram_web_o(web), .sram_wmask_o(wmask), .sram_addr_o(addr), .sram_din_o(din),
        .iram_dout_a_i(dout_a), .iram_dout_b_i(dout_b), .dram_dout_i(dout_d),
        .core_rst_n_o(core_rst_n)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_val(input int k);
        if (k == 2 * 256 + 1) return 32'h1357_9BDF;
        return (k * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] mexp(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    // Macro models: preload during reset, then sync read / masked write.
    logic [31:0] sm [3][256];
    int pl_idx = 0;
    always @(posedge clk) begin
        if (pl_idx < 768) begin
            sm[pl_idx / 256][pl_idx % 256] <= init_val(pl_idx);
            pl_idx <= pl_idx + 1;
        end else begin
            if (!csb_a) begin
                if (!web) sm[0][addr] <= (sm[0][addr] & ~mexp(wmask)) | (din & mexp(wmask));
                else      dout_a <= sm[0][addr];
            end
            if (!csb_b) begin
                if (!web) sm[1][addr] <= (sm[1][addr] & ~mexp(wmask)) | (din & mexp(wmask));
                else      dout_b <= sm[1][addr];
            end
            if (!csb_d) begin
                if (!web) sm[2][addr] <= (sm[2][addr] & ~mexp(wmask)) | (din & mexp(wmask));
                else      dout_d <= sm[2][addr];
            end
        end
    end

    // Reference state and per-cycle expectations.
    logic [31:0] ref_mem [3][256];
    logic        m_run = 1'b0;
    logic        exp_csb_a = 1'b1, exp_csb_b = 1'b1, exp_csb_d = 1'b1, exp_web = 1'b1;
    logic [3:0]  exp_wmask = 4'h0;
    logic [7:0]  exp_addr = 8'h0;
    logic [31:0] exp_din = 32'h0, exp_dat = 32'h0;
    logic        exp_ack = 1'b0, exp_core = 1'b0;

    always @(negedge clk) begin
        chk("iram_csb_a", {31'b0, csb_a}, {31'b0, exp_csb_a});
        chk("iram_csb_b", {31'b0, csb_b}, {31'b0, exp_csb_b});
        chk("dram_csb", {31'b0, csb_d}, {31'b0, exp_csb_d});
        chk("web", {31'b0, web}, {31'b0, exp_web});
        chk("wmask", {28'b0, wmask}, {28'b0, exp_wmask});
        chk("addr", {24'b0, addr}, {24'b0, exp_addr});
        chk("din", din, exp_din);
        chk("ack", {31'b0, ack}, {31'b0, exp_ack});
        chk("dat_o", dat_o, exp_dat);
        chk("core_rst_n", {31'b0, core_rst_n}, {31'b0, exp_core});
    end

    int         lat_seen;
    logic [2:0] cap_csb;
    logic [7:0] cap_addr;
    logic [3:0] cap_mask;

    task automatic set_idle();
        exp_csb_a = 1'b1; exp_csb_b = 1'b1; exp_csb_d = 1'b1;
        exp_web = 1'b1; exp_wmask = 4'h0; exp_ack = 1'b0;
    endtask

    // One bus transaction; drop_at = cycle (after the request edge) where cyc falls, 0 = never.
    task automatic txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input int drop_at);
        logic hit, ctrl, sram;
        logic [1:0] rg;
        logic [7:0] wd;
        logic [31:0] rval;
        int nlat, ncyc;
        hit  = (adr[31:12] == 20'h30000);
        rg   = adr[11:10];
        wd   = adr[9:2];
        ctrl = hit && (rg == 2'd3);
        sram = hit && !ctrl && !m_run;
        nlat = !hit ? 0 : (sram && !we) ? 3 : 2;
        ncyc = hit ? nlat + 1 : 10;
        if (sram)                  rval = ref_mem[rg][wd];
        else if (ctrl && wd == 0)  rval = {31'b0, m_run};
        else                       rval = 32'h0;
        lat_seen = 0; cap_csb = 3'b111; cap_addr = 8'h0; cap_mask = 4'h0;
        cyc = 1'b1; stb = 1'b1; we_i = we; adr_i = adr; dat_i = dat; sel_i = sel;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk); #1;
            if (c == drop_at || (hit && c == nlat + 1)) begin
                cyc = 1'b0; stb = 1'b0;
            end
            set_idle();
            if (c == 1 && sram) begin
                if (rg == 2'd0) exp_csb_a = 1'b0;
                else if (rg == 2'd1) exp_csb_b = 1'b0;
                else exp_csb_d = 1'b0;
                exp_web  = !we;
                exp_addr = wd;
                if (we) begin
                    exp_wmask = sel;
                    exp_din   = dat;
                    ref_mem[rg][wd] = (ref_mem[rg][wd] & ~mexp(sel)) | (dat & mexp(sel));
                end
            end
            if (c == 2 && ctrl && we && wd == 0 && sel[0]) m_run = dat[0];
            if (c == 3) exp_core = m_run;
            if (hit && c == nlat && (drop_at == 0 || drop_at >= nlat)) begin
                exp_ack = 1'b1;
                if (!we) exp_dat = rval;
            end
            if (c == 1) begin
                cap_csb = {csb_a, csb_b, csb_d}; cap_addr = addr; cap_mask = wmask;
            end
            if (ack && lat_seen == 0) lat_seen = c;
        end
    endtask

    task automatic rand_txn(input int max_region, input bit allow_drop);
        logic [31:0] a;
        logic w;
        int drop;
        w = 1'($urandom_range(0, 1));
        a = 32'h3000_0000 | (32'($urandom_range(0, max_region)) << 10) |
            (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(0, 3));
        if ($urandom_range(0, 9) == 0) a = 32'h4000_0000 | 32'($urandom_range(0, 4095));
        drop = (allow_drop && $urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
        txn(w, a, $urandom, 4'($urandom_range(0, 15)), drop);
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 768; k++) ref_mem[k / 256][k % 256] = init_val(k);
        repeat (780) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        txn(1'b1, 32'h3000_0004, 32'hA5A5_1234, 4'hF, 0);
        chk("wr_csb", {29'b0, cap_csb}, 32'h3);
        chk("wr_addr", {24'b0, cap_addr}, 32'h01);
        chk("wr_mask", {28'b0, cap_mask}, 32'hF);
        chk("wr_lat", lat_seen, 32'd2);

        txn(1'b0, 32'h3000_0804, 32'h0, 4'hF, 0);
        chk("rd_csb", {29'b0, cap_csb}, 32'h6);
        chk("rd_lat", lat_seen, 32'd3);
        chk("rd_dat", dat_o, 32'h1357_9BDF);

        txn(1'b1, 32'h3000_07FC, 32'hDEAD_BEEF, 4'h3, 0);
        chk("selb_csb", {29'b0, cap_csb}, 32'h5);
        chk("selb_mask", {28'b0, cap_mask}, 32'h3);
        chk("selb_addr", {24'b0, cap_addr}, 32'hFF);
        txn(1'b0, 32'h3000_07FC, 32'h0, 4'hF, 0);
        chk("selb_read", {16'b0, dat_o[15:0]}, 32'h0000_BEEF);

        txn(1'b1, 32'h3000_0010, 32'hFFFF_FFFF, 4'h0, 0);
        chk("sel0_lat", lat_seen, 32'd2);

        for (int i = 0; i < 150; i++) rand_txn(2, 1'b1);

        txn(1'b0, 32'h3000_0100, 32'h0, 4'hF, 2);
        chk("drop_rdw_lat", lat_seen, 32'd0);
        cyc = 1'b1; stb = 1'b1; we_i = 1'b1; adr_i = 32'h3000_0020; dat_i = 32'h0BAD_F00D; sel_i = 4'hF;
        @(posedge clk); #1;
        exp_csb_a = 1'b0; exp_web = 1'b0; exp_wmask = 4'hF; exp_addr = 8'h08; exp_din = 32'h0BAD_F00D;
        #2;
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0;
        #1;
        set_idle();
        exp_addr = 8'h0; exp_din = 32'h0; exp_dat = 32'h0; exp_core = 1'b0; m_run = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        txn(1'b1, 32'h3000_0024, 32'h1122_3344, 4'hF, 0);
        chk("post_rst_lat", lat_seen, 32'd2);

        txn(1'b1, 32'h3001_0000, 32'h1, 4'hF, 0);
        chk("miss_lat", lat_seen, 32'd0);
        chk("miss_csb", {29'b0, cap_csb}, 32'h7);

        txn(1'b1, 32'h3000_0C00, 32'h1, 4'hF, 0);
        chk("run_core", {31'b0, core_rst_n}, 32'h1);
        txn(1'b0, 32'h3000_0C00, 32'h0, 4'hF, 0);
        chk("run_read", dat_o, 32'h1);
        txn(1'b0, 32'h3000_0010, 32'h0, 4'hF, 0);
        chk("run_sram_dat", dat_o, 32'h0);
        chk("run_sram_lat", lat_seen, 32'd2);
        chk("run_sram_csb", {29'b0, cap_csb}, 32'h7);

        for (int i = 0; i < 60; i++) rand_txn(3, 1'b1);
        txn(1'b1, 32'h3000_0C00, 32'h0, 4'h1, 0);
        for (int i = 0; i < 40; i++) rand_txn(2, 1'b0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
